alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_seq_if.sv | 36 +++
 rtl/alu_mul_iter.sv | 59 +++++
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu_seq responder:
//   - opcode constants (OP_AND .. OP_MUL)
//   - FSM state encoding (IDLE, EXEC, MUL, RESP)
//   - op_is_legal(): which opcodes this build supports
// Optional feature macro: ALU_SEQ_MUL_EN (enables OP_MUL and the MUL state).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_e;
`else
  // Without the multiplier the MUL state does not exist at all.
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
`endif

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Request/response bundle between a requester (master) and alu_seq (slave).
//   req_valid/req_ready     : request handshake
//   req_inA/req_inB         : operands, WIDTH bits
//   req_operation           : 4-bit opcode
//   rsp_valid/rsp_ready     : response handshake
//   rsp_result              : WIDTH-bit result
//   rsp_zero/rsp_illegal    : result == 0 / unsupported opcode
// -----------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 32
) ();

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_inA;
  logic [WIDTH-1:0] req_inB;
  logic [3:0]       req_operation;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_illegal;

  modport master (
    output req_valid, req_inA, req_inB, req_operation, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

  modport slave (
    input  req_valid, req_inA, req_inB, req_operation, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

endinterface

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : load operands and start (WIDTH steps follow)
//   i_a, i_b   : multiplicand / multiplier, captured on i_start
//   o_done     : high during the final step
//   o_result   : low WIDTH bits of the product, valid while o_done is high
// -----------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // The last step's sum is presented combinationally, so the caller can
  // register the product on the same edge that completes the WIDTH-th step.
  assign o_done   = (r_cnt == CNT_W'(1));
  assign o_result = w_acc_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Handshaked, registered ALU responder: one request in, one response out.
// Basic ops answer two cycles after acceptance; the optional iterative
// multiply answers WIDTH+1 cycles after acceptance.
// Ports:
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset; drops any operation in flight
//   io_bus : alu_seq_if.slave (request and response channels)
// Optional feature macro: ALU_SEQ_MUL_EN (opcode 1000 = unsigned multiply).
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    io_bus
);

  state_e           r_state;
  state_e           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  logic             w_fire;
  logic             w_load_rsp;
  logic [WIDTH-1:0] w_basic_result;
  logic             w_illegal;
  logic [WIDTH-1:0] w_rsp_data;
  logic             w_rsp_illegal;

  // Handshake outputs depend on state only: no path from req_* or rsp_ready.
  assign io_bus.req_ready   = (r_state == IDLE);
  assign io_bus.rsp_valid   = (r_state == RESP);
  assign io_bus.rsp_result  = r_result;
  assign io_bus.rsp_zero    = r_zero;
  assign io_bus.rsp_illegal = r_illegal;

  assign w_fire    = io_bus.req_valid && (r_state == IDLE);
  assign w_illegal = !op_is_legal(r_op);

`ifdef ALU_SEQ_MUL_EN
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_result;

  // The multiplier captures the operands on the acceptance edge itself, so
  // its WIDTH steps begin in the first MUL cycle.
  assign w_mul_start = w_fire && (io_bus.req_operation == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_mul_start),
    .i_a      (io_bus.req_inA),
    .i_b      (io_bus.req_inB),
    .o_done   (w_mul_done),
    .o_result (w_mul_result)
  );
`endif

  // Basic-op datapath on the registered operands. Unsupported opcodes
  // (including OP_MUL, which never reaches this path legally) yield 0.
  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_basic_result = '0;
    case (r_op)
      OP_AND: w_basic_result = r_a & r_b;
      OP_OR:  w_basic_result = r_a | r_b;
      OP_ADD: w_basic_result = r_a + r_b;
      OP_SUB: w_basic_result = r_a - r_b;
      OP_SLT: w_basic_result[0] = ($signed(r_a) < $signed(r_b));
      OP_NOR: w_basic_result = ~(r_a | r_b);
      default: w_basic_result = '0;
    endcase
  end

  // Next-state and response-load control.
  always_comb begin
    w_state_next  = r_state;
    w_load_rsp    = 1'b0;
    w_rsp_data    = w_basic_result;
    w_rsp_illegal = w_illegal;
    case (r_state)
      IDLE: begin
        if (w_fire) begin
`ifdef ALU_SEQ_MUL_EN
          if (io_bus.req_operation == OP_MUL) w_state_next = MUL;
          else                                w_state_next = EXEC;
`else
          w_state_next = EXEC;
`endif
        end
      end
      EXEC: begin
        w_load_rsp   = 1'b1;
        w_state_next = RESP;
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        if (w_mul_done) begin
          w_load_rsp    = 1'b1;
          w_rsp_data    = w_mul_result;
          w_rsp_illegal = 1'b0;
          w_state_next  = RESP;
        end
      end
`endif
      RESP: begin
        if (io_bus.rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_fire) begin
        r_a  <= io_bus.req_inA;
        r_b  <= io_bus.req_inB;
        r_op <= io_bus.req_operation;
      end
      // Result registers change only on load, so they hold steady in RESP.
      if (w_load_rsp) begin
        r_result  <= w_rsp_data;
        r_zero    <= (w_rsp_data == '0);
        r_illegal <= w_rsp_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq. Directed requests are pushed into an
// expectation queue produced by an arithmetic model of the opcode table; a
// compare process checks every cycle a response is presented. Honors
// ALU_SEQ_MUL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
    int           lat;
    int           acc_cyc;
    bit           seen;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  exp_t         exp_q[$];
  logic [W-1:0] last_res;
  logic         last_zero;
  logic         last_ill;
  int           last_acc_cyc;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Opcode table evaluated with plain arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.res  = '0;
    e.ill  = 1'b0;
    e.lat  = 2;
    e.seen = 1'b0;
    e.acc_cyc = 0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: e.res = ~(a | b);
`ifdef ALU_SEQ_MUL_EN
      4'b1000: begin
        e.res = a * b;
        e.lat = W + 1;
      end
`endif
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Compare process: every cycle a response is presented.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      check("req_ready_low_in_resp", {31'd0, bus.req_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_rsp_valid", 32'd1, 32'd0);
      end else begin
        if (!exp_q[0].seen) begin
          check("rsp_latency", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
          exp_q[0].seen = 1'b1;
        end
        check("rsp_result",  bus.rsp_result,          exp_q[0].res);
        check("rsp_zero",    {31'd0, bus.rsp_zero},    {31'd0, exp_q[0].zero});
        check("rsp_illegal", {31'd0, bus.rsp_illegal}, {31'd0, exp_q[0].ill});
        last_res  = bus.rsp_result;
        last_zero = bus.rsp_zero;
        last_ill  = bus.rsp_illegal;
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Drives a request from posedge+1 and returns at posedge+1 after acceptance.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit   got;
    exp_t e;
    got = 1'b0;
    bus.req_valid     = 1'b1;
    bus.req_operation = op;
    bus.req_inA       = a;
    bus.req_inB       = b;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        e = model(op, a, b);
        e.acc_cyc = cyc;
        last_acc_cyc = cyc;
        exp_q.push_back(e);
        got = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (!got) check("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int limit);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) check("rsp_drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t m;
    int   t0;
    int   t1;
    int   k;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_operation = 4'b0000;
    bus.req_inA       = '0;
    bus.req_inB       = '0;
    bus.rsp_ready     = 1'b1;

    // Reset values.
    #1;
    check("reset_rsp_valid",   {31'd0, bus.rsp_valid},   32'd0);
    check("reset_rsp_result",  bus.rsp_result,           32'd0);
    check("reset_rsp_zero",    {31'd0, bus.rsp_zero},    32'd0);
    check("reset_rsp_illegal", {31'd0, bus.rsp_illegal}, 32'd0);
    #21 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Hand-computed pins on the model itself.
    m = model(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    check("model_add_wrap", m.res, 32'h0000_0000);
    m = model(4'b0111, 32'hFFFF_FFFE, 32'h0000_0003);
    check("model_slt_neg", m.res, 32'h0000_0001);
    m = model(4'b1111, 32'h1234_5678, 32'h1);
    check("model_illegal", {31'd0, m.ill}, 32'd1);

    // ADD with carry out discarded.
    send(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    drain(50);
    check("add_wrap_result", last_res, 32'h0000_0000);
    check("add_wrap_zero",   {31'd0, last_zero}, 32'd1);
    check("add_wrap_illegal", {31'd0, last_ill}, 32'd0);

    // SLT signed, both orders; SUB wrap.
    send(4'b0111, 32'hFFFF_FFFE, 32'h0000_0003);
    drain(50);
    check("slt_true_result", last_res, 32'h0000_0001);
    check("slt_true_zero",   {31'd0, last_zero}, 32'd0);
    send(4'b0111, 32'h0000_0003, 32'hFFFF_FFFE);
    drain(50);
    check("slt_false_result", last_res, 32'h0000_0000);
    send(4'b0110, 32'h0000_0005, 32'h0000_0007);
    drain(50);
    check("sub_wrap_result", last_res, 32'hFFFF_FFFE);

    // Remaining basic ops.
    send(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
    drain(50);
    check("and_result", last_res, 32'h00F0_1200);
    send(4'b0001, 32'hF000_0001, 32'h0000_0F10);
    drain(50);
    check("or_result", last_res, 32'hF000_0F11);

    // Unsupported opcode.
    send(4'b1111, 32'hDEAD_BEEF, 32'h1);
    drain(50);
    check("illegal_result",  last_res, 32'h0000_0000);
    check("illegal_zero",    {31'd0, last_zero}, 32'd1);
    check("illegal_flag",    {31'd0, last_ill},  32'd1);

    // Opcode 1000: 0x00010003 * 0x00020005 = 0x2_000B_000F.
    send(4'b1000, 32'h0001_0003, 32'h0002_0005);
    drain(100);
`ifdef ALU_SEQ_MUL_EN
    check("mul_result",  last_res, 32'h000B_000F);
    check("mul_illegal", {31'd0, last_ill}, 32'd0);
`else
    check("mul_off_result",  last_res, 32'h0000_0000);
    check("mul_off_illegal", {31'd0, last_ill}, 32'd1);
`endif

    // Backpressure: response held, new request ignored.
    bus.rsp_ready = 1'b0;
    send(4'b1100, 32'hFFFF_0000, 32'h0000_FFFF);
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.rsp_valid) check("bp_rsp_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid     = 1'b1;
    bus.req_operation = 4'b0010;
    bus.req_inA       = 32'h1;
    bus.req_inB       = 32'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid_held", {31'd0, bus.rsp_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain(50);
    check("bp_result", last_res, 32'h0000_0000);
    check("bp_zero",   {31'd0, last_zero}, 32'd1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;

    // Back-to-back basic ops with rsp_ready tied high: one per 3 cycles.
    send(4'b0010, 32'h0000_0010, 32'h0000_0020);
    t0 = last_acc_cyc;
    send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    t1 = last_acc_cyc;
    check("throughput_interval", t1 - t0, 32'd3);
    drain(50);
    check("b2b_result", last_res, 32'h8000_0000);

    // Reset in the middle of an operation.
    bus.rsp_ready = 1'b0;
    send(4'b1000, 32'h0001_0003, 32'h0002_0005);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid",   {31'd0, bus.rsp_valid},   32'd0);
    check("midrst_rsp_result",  bus.rsp_result,           32'd0);
    check("midrst_rsp_zero",    {31'd0, bus.rsp_zero},    32'd0);
    check("midrst_rsp_illegal", {31'd0, bus.rsp_illegal}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("midrst_no_rsp",    {31'd0, bus.rsp_valid}, 32'd0);
    bus.rsp_ready = 1'b1;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;

    // Still alive after the mid-operation reset.
    send(4'b0110, 32'h0000_0100, 32'h0000_0001);
    drain(50);
    check("post_rst_sub", last_res, 32'h0000_00FF);

    check("queue_empty_at_end", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got t=%0t expected below 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
